// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Entry select fields are sized for the largest supported register file.
package pipe_pkg;

   localparam int MIN_STAGES = 4;
   localparam int MAX_STAGES = 8;
   localparam int MAX_SEL_W  = 5;

   typedef logic [MAX_SEL_W-1:0] sel_t;

   typedef struct packed {
      logic valid;
      logic wr1_en;
      sel_t wr1_sel;
      logic wr2_en;
      sel_t wr2_sel;
   } hz_entry_t;

   function automatic logic sel_match(input logic en, input sel_t sel_a, input sel_t sel_b);
      return en & (sel_a == sel_b);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request and pipeline-control response bundle for pipe_hazard_ctrl.
// The master is the core pipeline; the slave is the hazard controller.
interface pipe_hazard_ctrl_if #(
   parameter int NUM_STAGES = 4,
   parameter int NUM_REGS   = 8,
   parameter int SEL_W      = $clog2(NUM_REGS),
   parameter int MC_W       = 4
);

   logic                  dec_valid;
   logic                  dec_rs1_en;
   logic                  dec_rs2_en;
   logic [SEL_W-1:0]      dec_rs1_sel;
   logic [SEL_W-1:0]      dec_rs2_sel;
   logic                  dec_wr1_en;
   logic                  dec_wr2_en;
   logic [SEL_W-1:0]      dec_wr1_sel;
   logic [SEL_W-1:0]      dec_wr2_sel;
   logic [MC_W-1:0]       dec_mc_cycles;
   logic                  branch_taken_E;
   logic                  halt_W;
   logic                  stall_FD;
   logic                  flush_D;
   logic                  bubble_E;
   logic                  hold_E;
   logic [NUM_STAGES-3:0] be_valid;
   logic                  halted;

   modport master (
      output dec_valid, dec_rs1_en, dec_rs2_en, dec_rs1_sel, dec_rs2_sel,
             dec_wr1_en, dec_wr2_en, dec_wr1_sel, dec_wr2_sel, dec_mc_cycles,
             branch_taken_E, halt_W,
      input  stall_FD, flush_D, bubble_E, hold_E, be_valid, halted
   );

   modport slave (
      input  dec_valid, dec_rs1_en, dec_rs2_en, dec_rs1_sel, dec_rs2_sel,
             dec_wr1_en, dec_wr2_en, dec_wr1_sel, dec_wr2_sel, dec_mc_cycles,
             branch_taken_E, halt_W,
      output stall_FD, flush_D, bubble_E, hold_E, be_valid, halted
   );

endinterface

// File: rtl/hz_compare.sv
// RAW hit detector: both decode sources against the destinations of one back-end entry.
module hz_compare
   import pipe_pkg::*;
(
   input  logic      rs1_en_i,
   input  sel_t      rs1_sel_i,
   input  logic      rs2_en_i,
   input  sel_t      rs2_sel_i,
   input  hz_entry_t entry_i,
   output logic      hit_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = sel_match(rs1_en_i & entry_i.wr1_en, rs1_sel_i, entry_i.wr1_sel) |
                    sel_match(rs1_en_i & entry_i.wr2_en, rs1_sel_i, entry_i.wr2_sel);
   assign rs2_hit = sel_match(rs2_en_i & entry_i.wr1_en, rs2_sel_i, entry_i.wr1_sel) |
                    sel_match(rs2_en_i & entry_i.wr2_en, rs2_sel_i, entry_i.wr2_sel);
   assign hit_o   = entry_i.valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/scoreboard controller for an in-order pipeline: F, D, then E..W.
// Optional macro PIPE_WB_BYPASS_EN: register file writes through, so W is not RAW-checked.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int NUM_REGS   = 8,
   parameter int SEL_W      = $clog2(NUM_REGS),
   parameter int MC_W       = 4
) (
   input logic               clock,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int BE   = NUM_STAGES - 2;
   localparam int LAST = BE - 1;
`ifdef PIPE_WB_BYPASS_EN
   localparam int CHK  = BE - 1;
`else
   localparam int CHK  = BE;
`endif

   hz_entry_t        ent_q [BE];
   hz_entry_t        ent_d [BE];
   hz_entry_t        dec_ent;
   logic [MC_W-1:0]  mc_q, mc_d;
   logic             halted_q, halted_d;
   logic [CHK-1:0]   hit;
   logic [BE-1:0]    be_valid_w;
   logic [SEL_W-1:0] rs1_sel, rs2_sel, wr1_sel, wr2_sel;
   logic             mc_busy, br_flush, hazard, issue;
   logic             stall_w, flush_w, bubble_w, hold_w;

   assign rs1_sel = bus.dec_rs1_sel;
   assign rs2_sel = bus.dec_rs2_sel;
   assign wr1_sel = bus.dec_wr1_sel;
   assign wr2_sel = bus.dec_wr2_sel;

   for (genvar g = 0; g < CHK; g++) begin : g_cmp
      hz_compare u_cmp (
         .rs1_en_i  (bus.dec_rs1_en),
         .rs1_sel_i (MAX_SEL_W'(rs1_sel)),
         .rs2_en_i  (bus.dec_rs2_en),
         .rs2_sel_i (MAX_SEL_W'(rs2_sel)),
         .entry_i   (ent_q[g]),
         .hit_o     (hit[g])
      );
   end

   // Control decisions, highest priority first
   always_comb begin
      mc_busy  = (mc_q != '0);
      br_flush = bus.branch_taken_E & ent_q[0].valid & ~mc_busy;
      hazard   = bus.dec_valid & (|hit);
      stall_w  = 1'b0;
      flush_w  = 1'b0;
      bubble_w = 1'b0;
      hold_w   = 1'b0;
      if (reset) begin
         flush_w  = 1'b1;
         bubble_w = 1'b1;
      end else if (halted_q) begin
         stall_w  = 1'b1;
         bubble_w = 1'b1;
      end else if (br_flush) begin
         flush_w  = 1'b1;
         bubble_w = 1'b1;
      end else if (mc_busy) begin
         hold_w   = 1'b1;
         stall_w  = 1'b1;
      end else if (hazard) begin
         stall_w  = 1'b1;
         bubble_w = 1'b1;
      end
      issue = bus.dec_valid & ~stall_w & ~flush_w & ~halted_q;
   end

   // Next state for the back-end shift chain, multi-cycle counter and halt flag
   always_comb begin
      dec_ent = '{valid:   1'b1,
                  wr1_en:  bus.dec_wr1_en,
                  wr1_sel: MAX_SEL_W'(wr1_sel),
                  wr2_en:  bus.dec_wr2_en,
                  wr2_sel: MAX_SEL_W'(wr2_sel)};
      ent_d[0] = hold_w ? ent_q[0] : (issue ? dec_ent : '0);
      ent_d[1] = hold_w ? '0 : ent_q[0];
      for (int i = 2; i < BE; i++) ent_d[i] = ent_q[i-1];
      mc_d = mc_q;
      if (issue)        mc_d = bus.dec_mc_cycles;
      else if (mc_busy) mc_d = mc_q - MC_W'(1);
      halted_d = halted_q | (bus.halt_W & ent_q[LAST].valid);
      for (int i = 0; i < BE; i++) be_valid_w[i] = ent_q[i].valid;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < BE; i++) ent_q[i] <= '0;
         mc_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         ent_q    <= ent_d;
         mc_q     <= mc_d;
         halted_q <= halted_d;
      end
   end

   assign bus.stall_FD = stall_w;
   assign bus.flush_D  = flush_w;
   assign bus.bubble_E = bubble_w;
   assign bus.hold_E   = hold_w;
   assign bus.be_valid = be_valid_w;
   assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; runs a 4-stage and a 6-stage instance side by side.
// Honours PIPE_WB_BYPASS_EN for the expected RAW stall lengths.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

`ifdef PIPE_WB_BYPASS_EN
   localparam int RAW4 = 1;
   localparam int RAW6 = 3;
`else
   localparam int RAW4 = 2;
   localparam int RAW6 = 4;
`endif

   pipe_hazard_ctrl_if #(.NUM_STAGES(4)) if4 ();
   pipe_hazard_ctrl_if #(.NUM_STAGES(6)) if6 ();

   pipe_hazard_ctrl #(.NUM_STAGES(4)) dut4 (.clock(clk), .reset(rst), .bus(if4));
   pipe_hazard_ctrl #(.NUM_STAGES(6)) dut6 (.clock(clk), .reset(rst), .bus(if6));

   task automatic drive(input logic v, input logic r1e, input logic [2:0] r1,
                        input logic r2e, input logic [2:0] r2,
                        input logic w1e, input logic [2:0] w1,
                        input logic w2e, input logic [2:0] w2, input logic [3:0] mc);
      if4.dec_valid = v;   if4.dec_rs1_en = r1e; if4.dec_rs1_sel = r1;
      if4.dec_rs2_en = r2e; if4.dec_rs2_sel = r2; if4.dec_wr1_en = w1e;
      if4.dec_wr1_sel = w1; if4.dec_wr2_en = w2e; if4.dec_wr2_sel = w2;
      if4.dec_mc_cycles = mc;
      if6.dec_valid = v;   if6.dec_rs1_en = r1e; if6.dec_rs1_sel = r1;
      if6.dec_rs2_en = r2e; if6.dec_rs2_sel = r2; if6.dec_wr1_en = w1e;
      if6.dec_wr1_sel = w1; if6.dec_wr2_en = w2e; if6.dec_wr2_sel = w2;
      if6.dec_mc_cycles = mc;
   endtask

   task automatic set_ctl(input logic br, input logic hlt);
      if4.branch_taken_E = br; if4.halt_W = hlt;
      if6.branch_taken_E = br; if6.halt_W = hlt;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
      set_ctl(1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 4'd2);
      set_ctl(1'b1, 1'b1);
      #1;
      n_vec++; if (if4.stall_FD !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", if4.stall_FD); end
      n_vec++; if (if4.flush_D  !== 1'b1) begin n_err++; $display("FAIL rst_flush: got %b want 1", if4.flush_D); end
      n_vec++; if (if4.bubble_E !== 1'b1) begin n_err++; $display("FAIL rst_bubble: got %b want 1", if4.bubble_E); end
      n_vec++; if (if4.hold_E   !== 1'b0) begin n_err++; $display("FAIL rst_hold: got %b want 0", if4.hold_E); end
      step();
      rst = 1'b0;
      idle();
      #1;
      n_vec++; if (if4.be_valid !== 2'b00) begin n_err++; $display("FAIL rst_bevalid4: got %b want 00", if4.be_valid); end
      n_vec++; if (if6.be_valid !== 4'b0000) begin n_err++; $display("FAIL rst_bevalid6: got %b want 0000", if6.be_valid); end
      n_vec++; if (if4.halted   !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", if4.halted); end
      n_vec++; if ({if4.stall_FD, if4.flush_D, if4.bubble_E, if4.hold_E} !== 4'b0000) begin
         n_err++; $display("FAIL rst_idle_outs: got %b want 0000", {if4.stall_FD, if4.flush_D, if4.bubble_E, if4.hold_E});
      end
   endtask

   task automatic raw_case(input int id,
                           input logic w1e, input logic [2:0] w1, input logic w2e, input logic [2:0] w2,
                           input logic r1e, input logic [2:0] r1, input logic r2e, input logic [2:0] r2,
                           input int exp4, input int exp6);
      int c4 = 0;
      int c6 = 0;
      do_reset();
      drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, w1e, w1, w2e, w2, 4'd0);
      #1;
      n_vec++; if (if4.stall_FD !== 1'b0) begin n_err++; $display("FAIL raw%0d_producer_issue: stall %b want 0", id, if4.stall_FD); end
      step();
      drive(1'b1, r1e, r1, r2e, r2, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
      for (int k = 0; k < 8; k++) begin
         #1;
         if (if4.stall_FD === 1'b1) begin
            c4++;
            n_vec++; if (if4.bubble_E !== 1'b1) begin n_err++; $display("FAIL raw%0d_bubble4 cyc%0d: got %b want 1", id, k, if4.bubble_E); end
         end
         if (if6.stall_FD === 1'b1) begin
            c6++;
            n_vec++; if (if6.bubble_E !== 1'b1) begin n_err++; $display("FAIL raw%0d_bubble6 cyc%0d: got %b want 1", id, k, if6.bubble_E); end
         end
         step();
      end
      n_vec++; if (c4 != exp4) begin n_err++; $display("FAIL raw%0d_stall4: got %0d cycles want %0d", id, c4, exp4); end
      n_vec++; if (c6 != exp6) begin n_err++; $display("FAIL raw%0d_stall6: got %0d cycles want %0d", id, c6, exp6); end
      idle();
   endtask

   task automatic test_raw();
      // wr1=wr2=R3, consumer reads R3 on rs1
      raw_case(1, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0, RAW4, RAW6);
      // only wr2 enabled (R5); consumer reads R5 on rs2, disabled rs1 names R4
      raw_case(2, 1'b0, 3'd4, 1'b1, 3'd5, 1'b0, 3'd4, 1'b1, 3'd5, RAW4, RAW6);
      // independent registers, disabled rs2 names the written register
      raw_case(3, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd3, 0, 0);
   endtask

   task automatic test_multicycle();
      do_reset();
      drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 3'd0, 4'd3);
      #1;
      n_vec++; if (if4.stall_FD !== 1'b0 || if4.hold_E !== 1'b0) begin n_err++; $display("FAIL mc_issue: stall %b hold %b want 0 0", if4.stall_FD, if4.hold_E); end
      step();
      drive(1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++; if (if4.hold_E   !== 1'b1) begin n_err++; $display("FAIL mc_hold cyc%0d: got %b want 1", k, if4.hold_E); end
         n_vec++; if (if4.stall_FD !== 1'b1) begin n_err++; $display("FAIL mc_stall cyc%0d: got %b want 1", k, if4.stall_FD); end
         n_vec++; if (if4.bubble_E !== 1'b0) begin n_err++; $display("FAIL mc_bubble cyc%0d: got %b want 0", k, if4.bubble_E); end
         n_vec++; if (if4.be_valid !== 2'b01) begin n_err++; $display("FAIL mc_bevalid cyc%0d: got %b want 01", k, if4.be_valid); end
         step();
      end
      #1;
      n_vec++; if (if4.hold_E !== 1'b0 || if4.stall_FD !== 1'b0) begin n_err++; $display("FAIL mc_complete: hold %b stall %b want 0 0", if4.hold_E, if4.stall_FD); end
      n_vec++; if (if4.be_valid !== 2'b01) begin n_err++; $display("FAIL mc_complete_bevalid: got %b want 01", if4.be_valid); end
      step();
      #1;
      n_vec++; if (if4.be_valid !== 2'b11) begin n_err++; $display("FAIL mc_advance_bevalid: got %b want 11", if4.be_valid); end
      idle();
   endtask

   task automatic test_branch();
      do_reset();
      drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd2);
      set_ctl(1'b1, 1'b0);
      #1;
      n_vec++; if (if4.flush_D !== 1'b0 || if4.stall_FD !== 1'b0) begin n_err++; $display("FAIL br_empty_E: flush %b stall %b want 0 0", if4.flush_D, if4.stall_FD); end
      step();
      drive(1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_vec++; if (if4.flush_D !== 1'b0) begin n_err++; $display("FAIL br_early_flush cyc%0d: got %b want 0", k, if4.flush_D); end
         n_vec++; if (if4.hold_E  !== 1'b1) begin n_err++; $display("FAIL br_hold cyc%0d: got %b want 1", k, if4.hold_E); end
         step();
      end
      #1;
      n_vec++; if ({if4.flush_D, if4.bubble_E, if4.stall_FD, if4.hold_E} !== 4'b1100) begin
         n_err++; $display("FAIL br_complete: flush/bubble/stall/hold got %b want 1100", {if4.flush_D, if4.bubble_E, if4.stall_FD, if4.hold_E});
      end
      step();
      #1;
      n_vec++; if (if4.flush_D !== 1'b0) begin n_err++; $display("FAIL br_after_flush: got %b want 0", if4.flush_D); end
      n_vec++; if (if4.be_valid[0] !== 1'b0) begin n_err++; $display("FAIL br_E_squashed: got %b want 0", if4.be_valid[0]); end
      // a taken branch overrides a RAW stall in the same cycle
      do_reset();
      drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 4'd0);
      step();
      drive(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
      set_ctl(1'b1, 1'b0);
      #1;
      n_vec++; if (if4.flush_D !== 1'b1 || if4.stall_FD !== 1'b0) begin n_err++; $display("FAIL br_over_raw: flush %b stall %b want 1 0", if4.flush_D, if4.stall_FD); end
      idle();
   endtask

   task automatic test_halt();
      do_reset();
      drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
      #1;
      n_vec++; if (if4.stall_FD !== 1'b0) begin n_err++; $display("FAIL halt_issue: stall %b want 0", if4.stall_FD); end
      step();
      idle();
      set_ctl(1'b0, 1'b1);
      #1;
      n_vec++; if (if4.halted !== 1'b0) begin n_err++; $display("FAIL halt_early: got %b want 0", if4.halted); end
      step();
      #1;
      n_vec++; if (if4.halted !== 1'b0) begin n_err++; $display("FAIL halt_W_invalid: got %b want 0", if4.halted); end
      n_vec++; if (if4.be_valid !== 2'b10) begin n_err++; $display("FAIL halt_in_W: be_valid %b want 10", if4.be_valid); end
      step();
      set_ctl(1'b0, 1'b0);
      drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++; if (if4.halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky cyc%0d: got %b want 1", k, if4.halted); end
         n_vec++; if (if4.stall_FD !== 1'b1 || if4.bubble_E !== 1'b1) begin n_err++; $display("FAIL halt_stall cyc%0d: stall %b bubble %b want 1 1", k, if4.stall_FD, if4.bubble_E); end
         n_vec++; if (if4.be_valid !== 2'b00) begin n_err++; $display("FAIL halt_no_issue cyc%0d: be_valid %b want 00", k, if4.be_valid); end
         step();
      end
      do_reset();
      #1;
      n_vec++; if (if4.halted !== 1'b0) begin n_err++; $display("FAIL halt_reset_clear: got %b want 0", if4.halted); end
   endtask

   task automatic test_reset_mc();
      do_reset();
      drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 4'd5);
      step();
      idle();
      step();
      #1;
      n_vec++; if (if4.hold_E !== 1'b1) begin n_err++; $display("FAIL rmc_busy: hold %b want 1", if4.hold_E); end
      rst = 1'b1;
      #1;
      n_vec++; if (if4.hold_E !== 1'b0 || if4.flush_D !== 1'b1) begin n_err++; $display("FAIL rmc_forced: hold %b flush %b want 0 1", if4.hold_E, if4.flush_D); end
      step();
      rst = 1'b0;
      #1;
      n_vec++; if (if4.hold_E !== 1'b0 || if4.stall_FD !== 1'b0) begin n_err++; $display("FAIL rmc_cleared: hold %b stall %b want 0 0", if4.hold_E, if4.stall_FD); end
      n_vec++; if (if4.be_valid !== 2'b00) begin n_err++; $display("FAIL rmc_bevalid: got %b want 00", if4.be_valid); end
      step();
      #1;
      n_vec++; if (if4.hold_E !== 1'b0) begin n_err++; $display("FAIL rmc_no_residual: hold %b want 0", if4.hold_E); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_raw();
      test_multicycle();
      test_branch();
      test_halt();
      test_reset_mc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
